// File: rtl/synthy_boy.sv
`timescale 1ns/1ps
// synthy_boy: two-oscillator DDS synth voice, configured over a byte-framed SPI slave.
// Each oscillator has accumulator, phase offset, waveform and amplitude; output is their registered mix.
module synthy_boy #(
    parameter int ACC_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk50mhz,
    input  logic               i_rst_n,
    input  logic               i_spi_clk,
    input  logic               i_spi_mosi,
    input  logic               i_spi_ss,
    output logic               o_spi_miso,
    output logic signed [15:0] o_data
);

    // state  | meaning
    // S_IDLE | next received byte is a command
    // S_DATA | collecting little-endian data bytes for r_cmd
    typedef enum logic {S_IDLE, S_DATA} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sck_prev;
    logic                   w_sck, w_ss, w_mosi, w_sck_rise, w_sck_fall;

    logic [6:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx_byte;
    logic        r_byte_vld;
    logic        r_miso;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cmd;
    logic [1:0]  r_len, r_idx, w_cmd_len;
    logic        w_cmd_ok, w_last, w_commit;
    logic [23:0] r_shadow, w_shadow_nxt;

    logic [2:0]         r_wave  [2];
    logic [23:0]        r_freq  [2];
    logic [15:0]        r_phase [2];
    logic [15:0]        r_amp   [2];
    logic [ACC_W-1:0]   r_acc   [2];
    logic [15:0]        r_p     [2];
    logic signed [15:0] r_s     [2];
    logic [7:0]         w_idx   [2];
    logic [14:0]        w_tri   [2];
    logic signed [15:0] w_w     [2];
    logic signed [32:0] w_prod  [2];
    logic signed [16:0] w_sum;
    logic [15:0]        w_lut   [256];

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_sck_prev  <= w_sck;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign o_spi_miso = r_miso;

    // MISO replays the last complete byte; index follows the bit count so the next bit is ready before SCK rises
    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_rx_byte  <= '0;
            r_byte_vld <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            if (w_ss) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_byte  <= {r_shift, w_mosi};
                    r_byte_vld <= 1'b1;
                end
            end else if (w_sck_fall) begin
                r_miso <= r_rx_byte[~r_bit_cnt];
            end
        end
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_cmd_len = 2'd0;
        case (r_rx_byte[3:0])
            4'h1:       w_cmd_len = 2'd1;
            4'h2:       w_cmd_len = 2'd3;
            4'h3, 4'h4: w_cmd_len = 2'd2;
            default:    w_cmd_len = 2'd0;
        endcase
        w_cmd_ok = (r_rx_byte[7:5] == 3'd0) && (w_cmd_len != 2'd0);
        w_last   = (r_idx == r_len - 2'd1);

        w_shadow_nxt = r_shadow;
        case (r_idx)
            2'd0:    w_shadow_nxt[7:0]   = r_rx_byte;
            2'd1:    w_shadow_nxt[15:8]  = r_rx_byte;
            default: w_shadow_nxt[23:16] = r_rx_byte;
        endcase

        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: if (r_byte_vld && w_cmd_ok) w_state_nxt = S_DATA;
            S_DATA: if (r_byte_vld && w_last) begin
                w_state_nxt = S_IDLE;
                w_commit    = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            for (int i = 0; i < 2; i++) begin
                r_wave[i]  <= '0;
                r_freq[i]  <= '0;
                r_phase[i] <= '0;
                r_amp[i]   <= '0;
            end
        end else if (r_byte_vld) begin
            if (r_state == S_IDLE) begin
                if (w_cmd_ok) begin
                    r_cmd    <= r_rx_byte[4:0];
                    r_len    <= w_cmd_len;
                    r_idx    <= '0;
                    r_shadow <= '0;
                end
            end else begin
                r_shadow <= w_shadow_nxt;
                r_idx    <= r_idx + 2'd1;
            end
            if (w_commit) begin
                case (r_cmd[3:0])
                    4'h1:    r_wave[r_cmd[4]]  <= w_shadow_nxt[2:0];
                    4'h2:    r_freq[r_cmd[4]]  <= w_shadow_nxt;
                    4'h3:    r_phase[r_cmd[4]] <= w_shadow_nxt[15:0];
                    4'h4:    r_amp[r_cmd[4]]   <= w_shadow_nxt[15:0];
                    default: ;
                endcase
            end
        end
    end

    // Quarter-wave table sampled at half-step offsets so mirroring needs no extra endpoint entry
    function automatic logic [15:0] f_sin(input int k);
        real r;
        r = 32767.0 * $sin(3.141592653589793 * (2.0 * k + 1.0) / 1024.0);
        return 16'($rtoi(r + 0.5));
    endfunction

    for (genvar g = 0; g < 256; g++) begin : g_lut
        assign w_lut[g] = f_sin(g);
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_idx[i] = r_p[i][14] ? ~r_p[i][13:6] : r_p[i][13:6];
            w_tri[i] = r_p[i][15] ? ~r_p[i][14:0] : r_p[i][14:0];
            case (r_wave[i])
                3'd1:    w_w[i] = {w_tri[i], 1'b0} - 16'h8000;
                3'd2:    w_w[i] = r_p[i] ^ 16'h8000;
                3'd3:    w_w[i] = r_p[i][15] ? 16'h8000 : 16'h7fff;
                3'd5:    w_w[i] = r_p[i][15] ? 16'h0000 - w_lut[w_idx[i]] : w_lut[w_idx[i]];
                default: w_w[i] = 16'sd0;
            endcase
            w_prod[i] = 33'(w_w[i]) * 33'($signed({1'b0, r_amp[i]}));
        end
        w_sum = 17'(r_s[0]) + 17'(r_s[1]);
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_acc[i] <= '0;
                r_p[i]   <= '0;
                r_s[i]   <= '0;
            end
            o_data <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_acc[i] <= r_acc[i] + ACC_W'(r_freq[i]);
                r_p[i]   <= r_acc[i][ACC_W-1 -: 16] + r_phase[i];
                r_s[i]   <= 16'(w_prod[i] >>> 16);
            end
            o_data <= 16'(w_sum >>> 1);
        end
    end

endmodule

// File: tb/tb_synthy_boy.sv
`timescale 1ns/1ps
// tb_synthy_boy: directed SPI configuration sequences with hand-computed output expectations.
module tb_synthy_boy;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               sck   = 1'b0;
    logic               mosi  = 1'b0;
    logic               ss    = 1'b1;
    logic               miso;
    logic signed [15:0] o_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    synthy_boy #(.ACC_W(32), .SYNC_STAGES(2)) dut (
        .i_clk50mhz (clk),
        .i_rst_n    (rst_n),
        .i_spi_clk  (sck),
        .i_spi_mosi (mosi),
        .i_spi_ss   (ss),
        .o_spi_miso (miso),
        .o_data     (o_data)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            clks(4);
            sck   = 1'b1;
            rx[i] = miso;
            clks(4);
            sck = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int n, output logic [7:0] rx_last);
        logic [7:0] bytes [4];
        bytes = '{b0, b1, b2, b3};
        rx_last = 8'h00;
        ss = 1'b0;
        clks(4);
        for (int i = 0; i < n; i++) spi_byte(bytes[i], rx_last);
        clks(4);
        ss = 1'b1;
        clks(12);
    endtask

    task automatic spi_write(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int n);
        logic [7:0] rx;
        spi_xfer(b0, b1, b2, b3, n, rx);
    endtask

    task automatic measure(input int n, output int mn, output int mx, output int small_drop,
                           output int big_drop, output int ups, output int max_step);
        int prev, cur, d;
        prev = o_data; mn = prev; mx = prev;
        small_drop = 0; big_drop = 0; ups = 0; max_step = 0;
        for (int i = 0; i < n; i++) begin
            clks(1);
            cur = o_data;
            d = cur - prev;
            if (d < 0) begin
                if (-d > 30000) big_drop++;
                else            small_drop++;
            end
            if (d > 0) ups++;
            if (d > max_step) max_step = d;
            if (-d > max_step) max_step = -d;
            if (cur < mn) mn = cur;
            if (cur > mx) mx = cur;
            prev = cur;
        end
    endtask

    task automatic test_reset;
        clks(3);
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d required 0", o_data); end
        n_tests++;
        if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b required 0", miso); end
        rst_n = 1'b1;
        clks(20);
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL idle_after_reset: got %0d required 0", o_data); end
    endtask

    task automatic test_square;
        int bad;
        spi_write(8'h01, 8'h03, 8'h00, 8'h00, 2);
        spi_write(8'h02, 8'hff, 8'hff, 8'h00, 4);
        spi_write(8'h04, 8'hff, 8'hff, 8'h00, 3);
        n_tests++;
        if (o_data !== 16'sd16383) begin n_fail++; $display("FAIL square_high: got %0d required 16383", o_data); end
        bad = 0;
        repeat (1000) begin clks(1); if (o_data !== 16'sd16383) bad++; end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL square_hold: got %0d off-level samples required 0", bad); end
    endtask

    task automatic test_freq24;
        int cnt, bad;
        logic found;
        logic signed [15:0] prev;
        spi_write(8'h02, 8'hff, 8'hff, 8'h03, 4);
        prev = o_data; found = 1'b0;
        for (int i = 0; i < 9000 && !found; i++) begin
            clks(1);
            if (o_data !== prev) found = 1'b1;
        end
        n_tests++;
        if (!found || o_data !== -16'sd16384) begin
            n_fail++; $display("FAIL square_first_edge: got found=%0b level %0d required 1 and -16384", found, o_data);
        end
        prev = o_data; found = 1'b0; cnt = 0; bad = 0;
        while (!found && cnt < 9000) begin
            clks(1);
            cnt++;
            if (o_data !== prev) found = 1'b1;
            if (o_data !== 16'sd16383 && o_data !== -16'sd16384) bad++;
        end
        n_tests++;
        if (!found || cnt < 8190 || cnt > 8194) begin
            n_fail++; $display("FAIL square_half_period: got %0d clocks (found=%0b) required 8190..8194", cnt, found);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL square_levels: got %0d bad samples required 0", bad); end
    endtask

    task automatic test_saw;
        int mn, mx, sd, bd, ups, st;
        spi_write(8'h02, 8'hff, 8'hff, 8'h0f, 4);
        spi_write(8'h01, 8'h02, 8'h00, 8'h00, 2);
        measure(4200, mn, mx, sd, bd, ups, st);
        n_tests++;
        if (sd != 0) begin n_fail++; $display("FAIL saw_monotonic: got %0d small drops required 0", sd); end
        n_tests++;
        if (bd < 1 || bd > 2) begin n_fail++; $display("FAIL saw_wraps: got %0d required 1..2", bd); end
        n_tests++;
        if (mx < 16370 || mx > 16383) begin n_fail++; $display("FAIL saw_max: got %0d required 16370..16383", mx); end
        n_tests++;
        if (mn < -16384 || mn > -16370) begin n_fail++; $display("FAIL saw_min: got %0d required -16384..-16370", mn); end
    endtask

    task automatic test_amp;
        int mn, mx, sd, bd, ups, st;
        spi_write(8'h04, 8'hff, 8'h7f, 8'h00, 3);
        measure(4200, mn, mx, sd, bd, ups, st);
        n_tests++;
        if (mx < 8180 || mx > 8191) begin n_fail++; $display("FAIL amp_half_max: got %0d required 8180..8191", mx); end
        n_tests++;
        if (mn < -8192 || mn > -8180) begin n_fail++; $display("FAIL amp_half_min: got %0d required -8192..-8180", mn); end
    endtask

    task automatic test_triangle;
        int mn, mx, sd, bd, ups, st;
        spi_write(8'h01, 8'h01, 8'h00, 8'h00, 2);
        measure(4200, mn, mx, sd, bd, ups, st);
        n_tests++;
        if (st > 16) begin n_fail++; $display("FAIL tri_step: got max step %0d required <=16", st); end
        n_tests++;
        if (ups == 0 || sd == 0) begin n_fail++; $display("FAIL tri_shape: got ups=%0d downs=%0d required both >0", ups, sd); end
        n_tests++;
        if (mx < 8180 || mx > 8191 || mn < -8192 || mn > -8180) begin
            n_fail++; $display("FAIL tri_range: got %0d..%0d required about -8192..8191", mn, mx);
        end
    endtask

    task automatic test_reset_mid;
        clks(1);
        #5 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL midreset_data: got %0d required 0", o_data); end
        n_tests++;
        if (miso !== 1'b0) begin n_fail++; $display("FAIL midreset_miso: got %b required 0", miso); end
        clks(5);
        rst_n = 1'b1;
        clks(20);
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL midreset_idle: got %0d required 0", o_data); end
    endtask

    task automatic test_phase_cancel;
        int bad;
        spi_write(8'h01, 8'h03, 8'h00, 8'h00, 2);
        spi_write(8'h02, 8'hff, 8'hff, 8'h00, 4);
        spi_write(8'h04, 8'hff, 8'hff, 8'h00, 3);
        spi_write(8'h11, 8'h03, 8'h00, 8'h00, 2);
        spi_write(8'h13, 8'h00, 8'h80, 8'h00, 3);
        spi_write(8'h12, 8'hff, 8'hff, 8'h00, 4);
        spi_write(8'h14, 8'hff, 8'hff, 8'h00, 3);
        n_tests++;
        if (o_data !== -16'sd1) begin n_fail++; $display("FAIL cancel_value: got %0d required -1", o_data); end
        bad = 0;
        repeat (2000) begin clks(1); if (o_data !== -16'sd1) bad++; end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL cancel_hold: got %0d off samples required 0", bad); end
    endtask

    task automatic test_robust;
        logic [7:0] rx;
        rst_n = 1'b0; clks(3); rst_n = 1'b1; clks(5);
        spi_write(8'h01, 8'h03, 8'h00, 8'h00, 2);
        spi_write(8'h04, 8'hff, 8'hff, 8'h00, 3);
        n_tests++;
        if (o_data !== 16'sd16383) begin n_fail++; $display("FAIL static_square: got %0d required 16383", o_data); end

        ss = 1'b0; clks(4);
        repeat (4) begin mosi = 1'b0; clks(4); sck = 1'b1; clks(4); sck = 1'b0; end
        clks(4); ss = 1'b1; clks(12);
        spi_write(8'h01, 8'h00, 8'h00, 8'h00, 2);
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL partial_byte: got %0d required 0", o_data); end

        spi_write(8'h01, 8'h03, 8'h00, 8'h00, 2);
        spi_write(8'h00, 8'h00, 8'h00, 8'h00, 1);
        n_tests++;
        if (o_data !== 16'sd16383) begin n_fail++; $display("FAIL nop_cmd: got %0d required 16383", o_data); end
        spi_write(8'h01, 8'h00, 8'h00, 8'h00, 1);
        spi_write(8'h00, 8'h00, 8'h00, 8'h00, 1);
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL split_frames: got %0d required 0", o_data); end

        spi_xfer(8'h5a, 8'h3c, 8'h00, 8'h00, 2, rx);
        n_tests++;
        if (rx !== 8'h5a) begin n_fail++; $display("FAIL miso_echo: got %h required 5a", rx); end

        spi_write(8'h01, 8'h05, 8'h00, 8'h00, 2);
        spi_write(8'h03, 8'h00, 8'h40, 8'h00, 3);
        n_tests++;
        if (o_data < 16381 || o_data > 16385) begin n_fail++; $display("FAIL sine_peak_pos: got %0d required 16381..16385", o_data); end
        spi_write(8'h03, 8'h00, 8'hc0, 8'h00, 3);
        n_tests++;
        if (o_data < -16385 || o_data > -16381) begin n_fail++; $display("FAIL sine_peak_neg: got %0d required -16385..-16381", o_data); end
        spi_write(8'h03, 8'h00, 8'h20, 8'h00, 3);
        n_tests++;
        if (o_data < 11485 || o_data > 11685) begin n_fail++; $display("FAIL sine_45: got %0d required 11485..11685", o_data); end
        spi_write(8'h03, 8'h00, 8'ha0, 8'h00, 3);
        n_tests++;
        if (o_data < -11685 || o_data > -11485) begin n_fail++; $display("FAIL sine_225: got %0d required -11685..-11485", o_data); end
        spi_write(8'h01, 8'h07, 8'h00, 8'h00, 2);
        n_tests++;
        if (o_data !== 16'sd0) begin n_fail++; $display("FAIL wave7_silent: got %0d required 0", o_data); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_freq24();
        test_saw();
        test_amp();
        test_triangle();
        test_reset_mid();
        test_phase_cancel();
        test_robust();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
